// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   HI/LO architectural register pair for the EX stage. Handles MTHI/MTLO,
//   signed/unsigned multiply, signed multiply-accumulate (single cycle) and
//   a radix-2 restoring divider that stalls the pipe via busy.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   op_valid  op/src_a/src_b valid this cycle
//   op        0 NOP,1 MTHI,2 MTLO,3 MULT,4 MULTU,5 DIV,6 DIVU,7 MADD
//   src_a     rs operand / dividend / MTHI,MTLO data
//   src_b     rt operand / divisor
//   flush     abort in-flight divide, drop same-cycle op
//   busy      divide in progress; new ops are ignored while high
//   done      one-cycle pulse once a divide result is on hi_o/lo_o
//   hi_o      current HI
//   lo_o      current LO
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MTHI  = 3'd1;
    localparam logic [2:0] OP_MTLO  = 3'd2;
    localparam logic [2:0] OP_MULT  = 3'd3;
    localparam logic [2:0] OP_MULTU = 3'd4;
    localparam logic [2:0] OP_DIV   = 3'd5;
    localparam logic [2:0] OP_DIVU  = 3'd6;
    localparam logic [2:0] OP_MADD  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t state_r, state_next_s;

    logic [WIDTH-1:0]   hi_r, lo_r;
    logic               done_r, busy_r;
    logic [WIDTH-1:0]   rem_r;      // partial remainder (always < divisor)
    logic [WIDTH-1:0]   quo_r;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   dvs_r;      // divisor magnitude
    logic [WIDTH-1:0]   dvd_r;      // raw dividend, returned in HI on divide-by-zero
    logic               q_neg_r, r_neg_r, dz_r;
    logic [CW-1:0]      count_r;

    logic               accept_s, div_start_s, last_step_s;
    logic               a_neg_s, b_neg_s;
    logic [WIDTH-1:0]   a_mag_s, b_mag_s;
    logic [WIDTH:0]     shift_s;
    logic [WIDTH+1:0]   diff_s;
    logic               fits_s;
    logic [WIDTH-1:0]   q_fin_s, r_fin_s;
    logic [2*WIDTH-1:0] a_sx_s, b_sx_s, prod_s_s, prod_u_s, madd_s;

    assign accept_s    = op_valid && (state_r == ST_IDLE) && !flush && (op != OP_NOP);
    assign div_start_s = accept_s && ((op == OP_DIV) || (op == OP_DIVU));
    assign last_step_s = (count_r == CW'(WIDTH - 1));

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign a_sx_s   = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    assign b_sx_s   = {{WIDTH{src_b[WIDTH-1]}}, src_b};
    assign prod_s_s = a_sx_s * b_sx_s;
    assign prod_u_s = {{WIDTH{1'b0}}, src_a} * {{WIDTH{1'b0}}, src_b};
    assign madd_s   = {hi_r, lo_r} + prod_s_s;

    // Operand magnitudes; MIN maps onto itself, which is the correct unsigned magnitude.
    assign a_neg_s = (op == OP_DIV) && src_a[WIDTH-1];
    assign b_neg_s = (op == OP_DIV) && src_b[WIDTH-1];
    assign a_mag_s = a_neg_s ? ({WIDTH{1'b0}} - src_a) : src_a;
    assign b_mag_s = b_neg_s ? ({WIDTH{1'b0}} - src_b) : src_b;

    // One restoring step; the extra top bit of diff_s is the borrow.
    assign shift_s = {rem_r, quo_r[WIDTH-1]};
    assign diff_s  = {1'b0, shift_s} - {2'b00, dvs_r};
    assign fits_s  = !diff_s[WIDTH+1];

    assign q_fin_s = q_neg_r ? ({WIDTH{1'b0}} - quo_r) : quo_r;
    assign r_fin_s = r_neg_r ? ({WIDTH{1'b0}} - rem_r) : rem_r;

    // Divider FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Divider FSM next-state logic; flush aborts from RUN or FIX.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (div_start_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    state_next_s = ST_IDLE;
                end else if (last_step_s) begin
                    state_next_s = ST_FIX;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_FIX:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // HI/LO, divider datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
            rem_r   <= {WIDTH{1'b0}};
            quo_r   <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            dvd_r   <= {WIDTH{1'b0}};
            q_neg_r <= 1'b0;
            r_neg_r <= 1'b0;
            dz_r    <= 1'b0;
            count_r <= {CW{1'b0}};
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_next_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        case (op)
                            OP_MTHI:  hi_r <= src_a;
                            OP_MTLO:  lo_r <= src_a;
                            OP_MULT:  {hi_r, lo_r} <= prod_s_s;
                            OP_MULTU: {hi_r, lo_r} <= prod_u_s;
                            OP_MADD:  {hi_r, lo_r} <= madd_s;
                            OP_DIV, OP_DIVU: begin
                                rem_r   <= {WIDTH{1'b0}};
                                quo_r   <= a_mag_s;
                                dvs_r   <= b_mag_s;
                                dvd_r   <= src_a;
                                q_neg_r <= a_neg_s ^ b_neg_s;
                                r_neg_r <= a_neg_s;
                                dz_r    <= (src_b == {WIDTH{1'b0}});
                                count_r <= {CW{1'b0}};
                            end
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (!flush) begin
                        rem_r   <= fits_s ? diff_s[WIDTH-1:0] : shift_s[WIDTH-1:0];
                        quo_r   <= {quo_r[WIDTH-2:0], fits_s};
                        count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        done_r <= 1'b1;
                        if (dz_r) begin
                            hi_r <= dvd_r;
                            lo_r <= {WIDTH{1'b1}};
                        end else begin
                            hi_r <= r_fin_s;
                            lo_r <= q_fin_s;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi_o = hi_r;
    assign lo_o = lo_r;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit (WIDTH=32). Inputs change 1 time unit
// after a rising edge; outputs are checked at that same point.
module tb_hilo_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int vectors = 0;
    int fails   = 0;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .op_valid (op_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        op_valid = 1'b1;
        op       = o;
        src_a    = a;
        src_b    = b;
        tick();
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    task automatic do_div(input string tag, input logic [2:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] pre_hi, input logic [31:0] pre_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        int overlap;
        n = 0;
        overlap = 0;
        issue(o, a, b);
        while (busy === 1'b1 && n < 100) begin
            if (done === 1'b1) overlap++;
            if (n == 16) begin
                chk({tag, "_hi_hold"}, {32'd0, hi_o}, {32'd0, pre_hi});
                chk({tag, "_lo_hold"}, {32'd0, lo_o}, {32'd0, pre_lo});
            end
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 64'(n), 64'd33);
        chk({tag, "_done_busy_overlap"}, 64'(overlap), 64'd0);
        chk({tag, "_done"}, {63'd0, done}, 64'd1);
        chk({tag, "_hi"}, {32'd0, hi_o}, {32'd0, exp_hi});
        chk({tag, "_lo"}, {32'd0, lo_o}, {32'd0, exp_lo});
        tick();
        chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    endtask

    initial begin
        int n;
        int dcount;
        rst      = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        src_a    = 32'd0;
        src_b    = 32'd0;
        flush    = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", {63'd0, busy}, 64'd0);
        chk("reset_done", {63'd0, done}, 64'd0);
        chk("reset_hi", {32'd0, hi_o}, 64'd0);
        chk("reset_lo", {32'd0, lo_o}, 64'd0);

        // MTHI / MTLO, then reset in the middle of a divide
        issue(3'd1, 32'h0000_00AA, 32'd0);
        chk("mthi_hi", {32'd0, hi_o}, 64'h0AA);
        chk("mthi_lo", {32'd0, lo_o}, 64'h0);
        issue(3'd2, 32'h0000_00BB, 32'd0);
        chk("mtlo_lo", {32'd0, lo_o}, 64'h0BB);
        chk("mtlo_hi", {32'd0, hi_o}, 64'h0AA);
        issue(3'd5, 32'd100, 32'd7);
        chk("div_start_busy", {63'd0, busy}, 64'd1);
        for (int i = 0; i < 10; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_done", {63'd0, done}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi_o}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo_o}, 64'd0);

        // Multiplies
        issue(3'd3, 32'hFFFF_FFFE, 32'd3);
        chk("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        issue(3'd4, 32'hFFFF_FFFE, 32'd3);
        chk("multu_hilo", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

        // MADD with borrow out of LO
        issue(3'd1, 32'h1, 32'd0);
        issue(3'd2, 32'h10, 32'd0);
        issue(3'd7, 32'd2, 32'd3);
        chk("madd1_hilo", {hi_o, lo_o}, 64'h0000_0001_0000_0016);
        issue(3'd7, 32'hFFFF_FFFF, 32'h17);
        chk("madd2_hilo", {hi_o, lo_o}, 64'h0000_0000_FFFF_FFFF);

        // flush in IDLE drops the op; op without op_valid is ignored
        flush = 1'b1;
        issue(3'd1, 32'h77, 32'd0);
        flush = 1'b0;
        chk("flush_idle_hi", {32'd0, hi_o}, 64'h0);
        op = 3'd2;
        src_a = 32'h99;
        tick();
        op = 3'd0;
        chk("novalid_lo", {32'd0, lo_o}, 64'hFFFF_FFFF);

        // Divides
        do_div("div_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h0, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFD);
        do_div("divu_7_2", 3'd6, 32'd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
               32'd1, 32'd3);
        do_div("div_7_m2", 3'd5, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'd3,
               32'd1, 32'hFFFF_FFFD);
        do_div("div_5_0", 3'd5, 32'd5, 32'd0, 32'd1, 32'hFFFF_FFFD,
               32'd5, 32'hFFFF_FFFF);
        do_div("divu_big", 3'd6, 32'hFFFF_FFFF, 32'h10, 32'd5, 32'hFFFF_FFFF,
               32'hF, 32'h0FFF_FFFF);
        do_div("div_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'hF, 32'h0FFF_FFFF,
               32'd0, 32'h8000_0000);

        // Flush at RUN step 5 with an MTLO presented while busy
        issue(3'd5, 32'd100, 32'd7);
        op_valid = 1'b1;
        op       = 3'd2;
        src_a    = 32'h55;
        for (int i = 0; i < 3; i++) tick();
        op_valid = 1'b0;
        op       = 3'd0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_run_busy", {63'd0, busy}, 64'd0);
        dcount = 0;
        n = 0;
        while (n < 40) begin
            if (done === 1'b1) dcount++;
            n++;
            tick();
        end
        chk("flush_run_no_done", 64'(dcount), 64'd0);
        chk("flush_run_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

        // Unit still usable after the abort
        issue(3'd2, 32'h55, 32'd0);
        chk("post_flush_mtlo", {32'd0, lo_o}, 64'h55);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
